// File: rtl/inert_pkg.sv
// Shared types and constants for the IMU sampler: FSM states, SPI command words,
// and the fixed-point constants of the pitch fusion filter.
package inert_pkg;

  typedef enum logic [3:0] {
    INIT_WAIT,
    INIT1,
    INIT2,
    INIT3,
    INIT4,
    WAIT_INT,
    RD_RTL,
    RD_RTH,
    RD_AZL,
    RD_AZH,
    UPDATE
  } state_e;

  localparam logic [15:0] CMD_INIT1  = 16'h0D02;  // INT on data ready
  localparam logic [15:0] CMD_INIT2  = 16'h1053;  // accel 208 Hz
  localparam logic [15:0] CMD_INIT3  = 16'h1150;  // gyro 208 Hz
  localparam logic [15:0] CMD_INIT4  = 16'h1460;  // rounding
  localparam logic [15:0] CMD_RD_RTL = 16'hA200;
  localparam logic [15:0] CMD_RD_RTH = 16'hA300;
  localparam logic [15:0] CMD_RD_AZL = 16'hAC00;
  localparam logic [15:0] CMD_RD_AZH = 16'hAD00;

  localparam logic [15:0]        PTCH_RT_OFFSET_DEF = 16'h0050;
  localparam logic signed [26:0] FUSION_MAG         = 27'sd1024;
  localparam logic signed [26:0] AZ_SCALE           = 27'sd327;

  function automatic logic [15:0] state_cmd(input state_e s);
    case (s)
      INIT1:   return CMD_INIT1;
      INIT2:   return CMD_INIT2;
      INIT3:   return CMD_INIT3;
      INIT4:   return CMD_INIT4;
      RD_RTL:  return CMD_RD_RTL;
      RD_RTH:  return CMD_RD_RTH;
      RD_AZL:  return CMD_RD_AZL;
      RD_AZH:  return CMD_RD_AZH;
      default: return 16'h0000;
    endcase
  endfunction

  function automatic state_e state_next(input state_e s);
    case (s)
      INIT1:   return INIT2;
      INIT2:   return INIT3;
      INIT3:   return INIT4;
      INIT4:   return WAIT_INT;
      RD_RTL:  return RD_RTH;
      RD_RTH:  return RD_AZL;
      RD_AZL:  return RD_AZH;
      RD_AZH:  return UPDATE;
      default: return WAIT_INT;
    endcase
  endfunction

endpackage

// File: rtl/spi_mnrch.sv
// 16-bit SPI master, mode 3 (SCLK idles high, SCLK = clk/16), 272-clk SS_n frame;
// done pulses with the SS_n rise, wrt while a frame is in progress is ignored.
module spi_mnrch (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wrt,
  input  logic [15:0] cmd,
  output logic        done,
  output logic [15:0] rd_data,
  output logic        SS_n,
  output logic        SCLK,
  output logic        MOSI,
  input  logic        MISO
);

  localparam logic [8:0] LAST_CNT = 9'd271;

  logic        ss_n_q, ss_n_d;
  logic        sclk_q, sclk_d;
  logic        mosi_q, mosi_d;
  logic        done_q, done_d;
  logic [15:0] shft_q, shft_d;
  logic [8:0]  cnt_q, cnt_d;

  // cnt_q counts clocks since SS_n fell: falls at 7+16k, rises at 15+16k for
  // k = 0..15, then SCLK rests high until SS_n rises after clock 271.
  always_comb begin
    ss_n_d = ss_n_q;
    sclk_d = sclk_q;
    mosi_d = mosi_q;
    shft_d = shft_q;
    cnt_d  = cnt_q;
    done_d = 1'b0;
    if (ss_n_q) begin
      if (wrt) begin
        ss_n_d = 1'b0;
        cnt_d  = '0;
        shft_d = cmd;
      end
    end else begin
      cnt_d = cnt_q + 9'd1;
      if (cnt_q == LAST_CNT) begin
        ss_n_d = 1'b1;
        done_d = 1'b1;
        mosi_d = 1'b0;
      end else if (!cnt_q[8]) begin
        if (cnt_q[3:0] == 4'd7) begin
          sclk_d = 1'b0;
          mosi_d = shft_q[15];
        end else if (cnt_q[3:0] == 4'd15) begin
          sclk_d = 1'b1;
          shft_d = {shft_q[14:0], MISO};
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ss_n_q <= 1'b1;
      sclk_q <= 1'b1;
      mosi_q <= 1'b0;
      done_q <= 1'b0;
      shft_q <= '0;
      cnt_q  <= '0;
    end else begin
      ss_n_q <= ss_n_d;
      sclk_q <= sclk_d;
      mosi_q <= mosi_d;
      done_q <= done_d;
      shft_q <= shft_d;
      cnt_q  <= cnt_d;
    end
  end

  assign SS_n    = ss_n_q;
  assign SCLK    = sclk_q;
  assign MOSI    = mosi_q;
  assign done    = done_q;
  assign rd_data = shft_q;

endmodule

// File: rtl/inert_sampler.sv
// IMU front end: configures the IMU over SPI, reads pitch rate and Z accel on each
// data-ready INT and fuses them into a pitch angle; vld strobes one clk after UPDATE.
module inert_sampler
  import inert_pkg::*;
#(
  parameter bit          fast_sim       = 1'b1,
  parameter logic [15:0] PTCH_RT_OFFSET = PTCH_RT_OFFSET_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               INT,
  input  logic               MISO,
  output logic               SS_n,
  output logic               SCLK,
  output logic               MOSI,
  output logic               vld,
  output logic signed [15:0] ptch,
  output logic signed [15:0] ptch_rt
);

  state_e             state_q;
  logic [15:0]        tmr_q;
  logic               sent_q;
  logic               wrt_q;
  logic [15:0]        cmd_q;
  logic               int_ff1_q, int_ff2_q;
  logic [7:0]         rtl_q, rth_q, azl_q, azh_q;
  logic signed [15:0] ptch_rt_q;
  logic signed [26:0] ptch_int_q, ptch_int_d;
  logic               vld_q;

  logic               done;
  logic [15:0]        rd_data;
  logic               tmr_done;

  spi_mnrch u_spi (
    .clk    (clk),
    .rst_n  (rst_n),
    .wrt    (wrt_q),
    .cmd    (cmd_q),
    .done   (done),
    .rd_data(rd_data),
    .SS_n   (SS_n),
    .SCLK   (SCLK),
    .MOSI   (MOSI),
    .MISO   (MISO)
  );

  assign tmr_done = fast_sim ? (tmr_q[9:0] == 10'h3FF) : (tmr_q == 16'hFFFF);

  logic [15:0]        rt_new;
  logic [15:0]        comp;
  logic signed [26:0] az_ext, az_prod, az_shr;
  logic signed [15:0] ptch_acc;
  logic signed [26:0] fusion;
  logic               unused_bits;

  // The integrator step uses the freshly read rate, not the registered ptch_rt.
  assign rt_new     = {rth_q, rtl_q};
  assign comp       = rt_new - PTCH_RT_OFFSET;
  assign az_ext     = $signed({{11{azh_q[7]}}, azh_q, azl_q});
  assign az_prod    = az_ext * AZ_SCALE;
  assign az_shr     = az_prod >>> 13;
  assign ptch_acc   = az_shr[15:0];
  assign fusion     = (ptch_acc > ptch) ? FUSION_MAG : -FUSION_MAG;
  assign ptch_int_d = ptch_int_q - $signed({{11{comp[15]}}, comp}) + fusion;
  assign unused_bits = &{1'b0, rd_data[15:8], az_shr[26:16]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= INIT_WAIT;
      tmr_q      <= '0;
      sent_q     <= 1'b0;
      wrt_q      <= 1'b0;
      cmd_q      <= '0;
      int_ff1_q  <= 1'b0;
      int_ff2_q  <= 1'b0;
      rtl_q      <= '0;
      rth_q      <= '0;
      azl_q      <= '0;
      azh_q      <= '0;
      ptch_rt_q  <= '0;
      ptch_int_q <= '0;
      vld_q      <= 1'b0;
    end else begin
      int_ff1_q <= INT;
      int_ff2_q <= int_ff1_q;
      wrt_q     <= 1'b0;
      vld_q     <= 1'b0;
      case (state_q)
        INIT_WAIT: begin
          tmr_q <= tmr_q + 16'd1;
          if (tmr_done) state_q <= INIT1;
        end
        WAIT_INT: begin
          if (int_ff2_q) state_q <= RD_RTL;
        end
        UPDATE: begin
          ptch_rt_q  <= rt_new;
          ptch_int_q <= ptch_int_d;
          vld_q      <= 1'b1;
          state_q    <= WAIT_INT;
        end
        default: begin
          // Command states: one wrt per state, advance when the frame completes.
          if (!sent_q) begin
            wrt_q  <= 1'b1;
            cmd_q  <= state_cmd(state_q);
            sent_q <= 1'b1;
          end else if (done) begin
            sent_q  <= 1'b0;
            state_q <= state_next(state_q);
            case (state_q)
              RD_RTL:  rtl_q <= rd_data[7:0];
              RD_RTH:  rth_q <= rd_data[7:0];
              RD_AZL:  azl_q <= rd_data[7:0];
              RD_AZH:  azh_q <= rd_data[7:0];
              default: ;
            endcase
          end
        end
      endcase
    end
  end

  assign vld     = vld_q;
  assign ptch    = ptch_int_q[26:11];
  assign ptch_rt = ptch_rt_q;

endmodule

// File: tb/tb_inert_sampler.sv
// Directed bench: IMU SPI slave model, frame/vld monitors and per-scenario checks.
module tb_inert_sampler;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic INT = 1'b0;
  logic MISO = 1'b0;
  logic SS_n, SCLK, MOSI, vld;
  logic signed [15:0] ptch, ptch_rt;

  inert_sampler #(.fast_sim(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .INT(INT), .MISO(MISO),
    .SS_n(SS_n), .SCLK(SCLK), .MOSI(MOSI),
    .vld(vld), .ptch(ptch), .ptch_rt(ptch_rt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  // IMU slave model
  logic [15:0] imu_rt = 16'h0050;
  logic [15:0] imu_az = 16'h0000;
  logic [15:0] rx = '0;
  logic [7:0]  rbyte = '0;
  int nb = 0, nf = 0, lowcnt = 0;
  logic [15:0] words[$];
  int flen[$];
  int fstart[$];

  always @(negedge SS_n) begin
    nb = 0; nf = 0; rx = '0; lowcnt = 0;
    fstart.push_back(cyc);
  end
  always @(negedge clk) if (SS_n === 1'b0) lowcnt++;
  always @(posedge SS_n) if (nb == 16) begin
    words.push_back(rx);
    flen.push_back(lowcnt);
  end
  always @(posedge SCLK) if (SS_n === 1'b0) begin
    rx = {rx[14:0], MOSI};
    nb++;
  end
  always @(negedge SCLK) if (SS_n === 1'b0) begin
    if (nf == 8) begin
      case (rx[7:0])
        8'hA2:   rbyte = imu_rt[7:0];
        8'hA3:   rbyte = imu_rt[15:8];
        8'hAC:   rbyte = imu_az[7:0];
        8'hAD:   rbyte = imu_az[15:8];
        default: rbyte = 8'h00;
      endcase
    end
    if (nf >= 8 && nf < 16) MISO = rbyte[15-nf];
    else MISO = 1'b0;
    nf++;
  end

  // vld monitor
  int vld_cnt = 0, vld_wide = 0;
  logic prev_vld = 1'b0;
  int vcyc[$];
  logic signed [15:0] vptch[$];
  logic signed [15:0] vrt[$];
  always @(negedge clk) begin
    if (vld === 1'b1) begin
      vld_cnt++;
      vcyc.push_back(cyc);
      vptch.push_back(ptch);
      vrt.push_back(ptch_rt);
      if (prev_vld) vld_wide++;
    end
    prev_vld = (vld === 1'b1);
  end

  // Reference filter
  int m_int = 0;
  task automatic model_step(input logic [15:0] rt, input logic [15:0] az);
    logic [15:0] c16;
    int comp, acc, p, fus;
    c16  = rt - 16'h0050;
    comp = $signed(c16);
    acc  = ($signed(az) * 327) >>> 13;
    p    = m_int >>> 11;
    fus  = (acc > p) ? 1024 : -1024;
    m_int = m_int - comp + fus;
  endtask

  function automatic logic signed [15:0] exp_ptch();
    return 16'(m_int >>> 11);
  endfunction

  function automatic int cur_cnt(input int sel);
    case (sel)
      0:       return vld_cnt;
      1:       return words.size();
      default: return fstart.size();
    endcase
  endfunction

  task automatic wait_cnt(input int sel, input int target, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (cur_cnt(sel) >= target) begin ok = 1'b1; break; end
    end
  endtask

  task automatic pulse_int();
    @(negedge clk) INT = 1'b1;
    repeat (3) @(negedge clk);
    INT = 1'b0;
  endtask

  logic [15:0] init_w[4] = '{16'h0D02, 16'h1053, 16'h1150, 16'h1460};
  logic [15:0] rd_w[4]   = '{16'hA200, 16'hA300, 16'hAC00, 16'hAD00};

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (SS_n !== 1'b1)     begin bad++; $display("FAIL reset_ss_n got=%b exp=1", SS_n); end
    total++; if (SCLK !== 1'b1)     begin bad++; $display("FAIL reset_sclk got=%b exp=1", SCLK); end
    total++; if (MOSI !== 1'b0)     begin bad++; $display("FAIL reset_mosi got=%b exp=0", MOSI); end
    total++; if (vld !== 1'b0)      begin bad++; $display("FAIL reset_vld got=%b exp=0", vld); end
    total++; if (ptch !== 16'sd0)   begin bad++; $display("FAIL reset_ptch got=%0d exp=0", ptch); end
    total++; if (ptch_rt !== 16'sd0) begin bad++; $display("FAIL reset_ptch_rt got=%0d exp=0", ptch_rt); end
  endtask

  task automatic test_init();
    int rel, fb, sb;
    bit ok;
    fb = words.size(); sb = fstart.size();
    @(negedge clk) rst_n = 1'b1;
    rel = cyc;
    wait_cnt(1, fb + 4, 2800, ok);
    repeat (600) @(negedge clk);
    total++; if (!ok) begin bad++; $display("FAIL init_timeout got=%0d frames exp=4", words.size() - fb); end
    total++; if (words.size() != fb + 4) begin bad++; $display("FAIL init_frame_count got=%0d exp=4", words.size() - fb); end
    if (ok) begin
      for (int i = 0; i < 4; i++) begin
        total++; if (words[fb+i] !== init_w[i]) begin bad++; $display("FAIL init_word%0d got=%h exp=%h", i, words[fb+i], init_w[i]); end
        total++; if (flen[fb+i] != 272) begin bad++; $display("FAIL init_sslow%0d got=%0d exp=272", i, flen[fb+i]); end
      end
      total++; if (fstart[sb] - rel < 1024 || fstart[sb] - rel > 1100) begin
        bad++; $display("FAIL init_wait got=%0d exp=1024..1100", fstart[sb] - rel); end
    end
    total++; if (vld_cnt != 0) begin bad++; $display("FAIL init_vld got=%0d exp=0", vld_cnt); end
  endtask

  task automatic test_single_read();
    int fb, vb;
    bit ok;
    fb = words.size(); vb = vld_cnt;
    imu_rt = 16'h0050; imu_az = 16'h0000;
    pulse_int();
    wait_cnt(0, vb + 1, 1400, ok);
    repeat (300) @(negedge clk);
    total++; if (!ok) begin bad++; $display("FAIL single_timeout got=no vld exp=vld"); end
    total++; if (vld_cnt != vb + 1) begin bad++; $display("FAIL single_vld_count got=%0d exp=1", vld_cnt - vb); end
    total++; if (vld_wide != 0) begin bad++; $display("FAIL single_vld_width got=%0d wide exp=0", vld_wide); end
    total++; if (words.size() != fb + 4) begin bad++; $display("FAIL single_frames got=%0d exp=4", words.size() - fb); end
    if (ok && words.size() >= fb + 4) begin
      for (int i = 0; i < 4; i++) begin
        total++; if (words[fb+i] !== rd_w[i]) begin bad++; $display("FAIL single_cmd%0d got=%h exp=%h", i, words[fb+i], rd_w[i]); end
      end
      model_step(16'h0050, 16'h0000);
      total++; if (vrt[vb] !== 16'sh0050) begin bad++; $display("FAIL single_ptch_rt got=%h exp=0050", vrt[vb]); end
      total++; if (vptch[vb] !== -16'sd1) begin bad++; $display("FAIL single_ptch got=%0d exp=-1", vptch[vb]); end
      total++; if (ptch !== -16'sd1) begin bad++; $display("FAIL single_ptch_hold got=%0d exp=-1", ptch); end
    end
  endtask

  task automatic test_accel();
    logic [15:0] rts[2] = '{16'hF050, 16'h0050};
    logic [15:0] azs[2] = '{16'h4000, 16'hC000};
    logic signed [15:0] pexp[2] = '{16'sd2, 16'sd1};
    int vb;
    bit ok;
    for (int i = 0; i < 2; i++) begin
      vb = vld_cnt;
      imu_rt = rts[i]; imu_az = azs[i];
      pulse_int();
      wait_cnt(0, vb + 1, 1400, ok);
      total++; if (!ok) begin bad++; $display("FAIL accel%0d_timeout got=no vld exp=vld", i); end
      if (ok) begin
        model_step(rts[i], azs[i]);
        total++; if (vrt[vb] !== $signed(rts[i])) begin bad++; $display("FAIL accel%0d_ptch_rt got=%h exp=%h", i, vrt[vb], rts[i]); end
        total++; if (vptch[vb] !== pexp[i] || vptch[vb] !== exp_ptch()) begin
          bad++; $display("FAIL accel%0d_ptch got=%0d exp=%0d", i, vptch[vb], pexp[i]); end
      end
      repeat (50) @(negedge clk);
    end
  endtask

  task automatic test_int_during_azl();
    int fb, vb, sb;
    bit ok1, ok2;
    fb = words.size(); vb = vld_cnt; sb = fstart.size();
    imu_rt = 16'h0050; imu_az = 16'h0000;
    pulse_int();
    wait_cnt(2, sb + 3, 1000, ok1);
    repeat (50) @(negedge clk);
    pulse_int();
    wait_cnt(0, vb + 1, 1200, ok2);
    repeat (1400) @(negedge clk);
    total++; if (!ok1 || !ok2) begin bad++; $display("FAIL azl_timeout got=%0d%0d exp=11", ok1, ok2); end
    total++; if (vld_cnt != vb + 1) begin bad++; $display("FAIL azl_vld_count got=%0d exp=1", vld_cnt - vb); end
    total++; if (fstart.size() != sb + 4) begin bad++; $display("FAIL azl_frames got=%0d exp=4", fstart.size() - sb); end
    if (ok2) begin
      model_step(16'h0050, 16'h0000);
      total++; if (vptch[vb] !== exp_ptch()) begin bad++; $display("FAIL azl_ptch got=%0d exp=%0d", vptch[vb], exp_ptch()); end
    end
  endtask

  task automatic test_back_to_back();
    int vb, sp, sp0;
    bit ok;
    logic signed [15:0] prev;
    vb = vld_cnt; sp0 = 0; prev = ptch;
    imu_rt = 16'h0850; imu_az = 16'h0000;
    @(negedge clk) INT = 1'b1;
    for (int i = 0; i < 40; i++) begin
      wait_cnt(0, vb + i + 1, 1300, ok);
      total++; if (!ok) begin bad++; $display("FAIL b2b_timeout event=%0d got=no vld exp=vld", i); break; end
      model_step(16'h0850, 16'h0000);
      total++; if (vptch[vb+i] !== exp_ptch()) begin bad++; $display("FAIL b2b_ptch%0d got=%0d exp=%0d", i, vptch[vb+i], exp_ptch()); end
      total++; if (vptch[vb+i] > prev) begin bad++; $display("FAIL b2b_monotonic%0d got=%0d exp<=%0d", i, vptch[vb+i], prev); end
      total++; if (vrt[vb+i] !== 16'sh0850) begin bad++; $display("FAIL b2b_ptch_rt%0d got=%h exp=0850", i, vrt[vb+i]); end
      prev = vptch[vb+i];
      if (i >= 1) begin
        sp = vcyc[vb+i] - vcyc[vb+i-1];
        if (i == 1) begin
          sp0 = sp;
          total++; if (sp < 1088 || sp > 1120) begin bad++; $display("FAIL b2b_spacing got=%0d exp=1088..1120", sp); end
        end else begin
          total++; if (sp != sp0) begin bad++; $display("FAIL b2b_spacing%0d got=%0d exp=%0d", i, sp, sp0); end
        end
      end
    end
    INT = 1'b0;
    // INT was still high through the double flop when vld fired, so one more read follows.
    wait_cnt(0, vb + 41, 1300, ok);
    repeat (1300) @(negedge clk);
    total++; if (vld_cnt != vb + 41) begin bad++; $display("FAIL b2b_tail got=%0d exp=41", vld_cnt - vb); end
    if (ok) model_step(16'h0850, 16'h0000);
    total++; if (ptch !== exp_ptch()) begin bad++; $display("FAIL b2b_final_ptch got=%0d exp=%0d", ptch, exp_ptch()); end
    total++; if (vld_wide != 0) begin bad++; $display("FAIL b2b_vld_width got=%0d exp=0", vld_wide); end
  endtask

  task automatic test_reset_mid();
    int vb, sb, fb, rel;
    bit ok;
    vb = vld_cnt; sb = fstart.size();
    imu_rt = 16'h0050; imu_az = 16'h0000;
    pulse_int();
    wait_cnt(2, sb + 2, 1000, ok);
    repeat (100) @(negedge clk);
    total++; if (!ok || SS_n !== 1'b0) begin bad++; $display("FAIL mid_in_frame got=%b exp=0", SS_n); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (SS_n !== 1'b1)      begin bad++; $display("FAIL mid_ss_n got=%b exp=1", SS_n); end
    total++; if (vld !== 1'b0)       begin bad++; $display("FAIL mid_vld got=%b exp=0", vld); end
    total++; if (ptch !== 16'sd0)    begin bad++; $display("FAIL mid_ptch got=%0d exp=0", ptch); end
    total++; if (ptch_rt !== 16'sd0) begin bad++; $display("FAIL mid_ptch_rt got=%0d exp=0", ptch_rt); end
    m_int = 0;
    repeat (3) @(negedge clk);
    fb = words.size(); sb = fstart.size();
    rst_n = 1'b1;
    rel = cyc;
    wait_cnt(1, fb + 4, 2800, ok);
    repeat (300) @(negedge clk);
    total++; if (!ok) begin bad++; $display("FAIL mid_reinit_timeout got=%0d exp=4", words.size() - fb); end
    if (ok) begin
      for (int i = 0; i < 4; i++) begin
        total++; if (words[fb+i] !== init_w[i]) begin bad++; $display("FAIL mid_init_word%0d got=%h exp=%h", i, words[fb+i], init_w[i]); end
      end
      total++; if (fstart[sb] - rel < 1024 || fstart[sb] - rel > 1100) begin
        bad++; $display("FAIL mid_init_wait got=%0d exp=1024..1100", fstart[sb] - rel); end
    end
    total++; if (vld_cnt != vb) begin bad++; $display("FAIL mid_vld_count got=%0d exp=0", vld_cnt - vb); end
  endtask

  initial begin
    test_reset();
    test_init();
    test_single_read();
    test_accel();
    test_int_during_azl();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule
